// File: rtl/axis_operand_join_pkg.sv
// Shared constants and state encodings for the operand-join block and its
// output register slice.
package axis_operand_join_pkg;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_CNT_W = 16;

    // Output stage occupancy without the skid register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Output stage occupancy with the skid register (output + skid entries).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Output register slice for the joined stream. Define AXIS_JOIN_SKID_EN to add
// a one-entry skid register that breaks the m_axis_tready -> accept path.
module axis_reg_slice
    import axis_operand_join_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_SIZE
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_fire,
    output logic             accept,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

`ifdef AXIS_JOIN_SKID_EN

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Next-state: a fire that cannot go to the output lands in the skid entry.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    out_d   = in_data;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (out_ready && in_fire) begin
                    out_d   = in_data;
                    state_d = ONE;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                if (out_ready) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // Accept depends only on registered state.
    assign accept    = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_q;

`else

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;

    // Next-state: a simultaneous drain and fire keeps the stage full with new data.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            OUT_EMPTY: begin
                if (in_fire) begin
                    out_d   = in_data;
                    state_d = OUT_FULL;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (in_fire) begin
                    out_d   = in_data;
                    state_d = OUT_FULL;
                end else if (out_ready) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= OUT_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Accept is combinational from out_ready in this build.
    assign out_valid = (state_q == OUT_FULL);
    assign accept    = !out_valid || out_ready;
    assign out_data  = out_q;

`endif

endmodule

// File: rtl/axis_operand_join.sv
// Joins operand streams A and B into one {B,A} beat per fire and counts fires.
// Define AXIS_JOIN_SKID_EN for a registered (skid-buffered) accept.
module axis_operand_join
    import axis_operand_join_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [SIZE-1:0]   s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic [SIZE-1:0]   s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    output logic [2*SIZE-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  join_count
);

    logic             accept_s;
    logic             fire_s;
    logic [CNT_W-1:0] count_q, count_d;

    // Both operands are consumed together or not at all; nothing is taken in reset.
    assign fire_s          = aresetn && accept_s && s_axis_a_tvalid && s_axis_b_tvalid;
    assign s_axis_a_tready = fire_s;
    assign s_axis_b_tready = fire_s;

    axis_reg_slice #(
        .WIDTH (2 * SIZE)
    ) u_slice (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   ({s_axis_b_tdata, s_axis_a_tdata}),
        .in_fire   (fire_s),
        .accept    (accept_s),
        .out_data  (m_axis_tdata),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    // Fire counter, wraps naturally at 2^CNT_W.
    always_comb begin
        if (fire_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign join_count = count_q;

endmodule

// File: tb/tb_axis_operand_join.sv
// Directed and randomized self-checking bench for axis_operand_join.
module tb_axis_operand_join;

`ifdef AXIS_JOIN_SKID_EN
    localparam int STALL_ACCEPT = 2;
`else
    localparam int STALL_ACCEPT = 1;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tready, b_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tready;
    logic [15:0] join_count;

    logic [7:0]  c4_a_tdata, c4_b_tdata;
    logic        c4_a_tvalid, c4_b_tvalid, c4_a_tready, c4_b_tready;
    logic [15:0] c4_m_tdata;
    logic        c4_m_tvalid, c4_m_tready;
    logic [3:0]  c4_join_count;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_operand_join #(.SIZE(32), .CNT_W(16)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_a_tdata  (a_tdata),
        .s_axis_a_tvalid (a_tvalid),
        .s_axis_a_tready (a_tready),
        .s_axis_b_tdata  (b_tdata),
        .s_axis_b_tvalid (b_tvalid),
        .s_axis_b_tready (b_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .join_count      (join_count)
    );

    axis_operand_join #(.SIZE(8), .CNT_W(4)) dut4 (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_a_tdata  (c4_a_tdata),
        .s_axis_a_tvalid (c4_a_tvalid),
        .s_axis_a_tready (c4_a_tready),
        .s_axis_b_tdata  (c4_b_tdata),
        .s_axis_b_tvalid (c4_b_tvalid),
        .s_axis_b_tready (c4_b_tready),
        .m_axis_tdata    (c4_m_tdata),
        .m_axis_tvalid   (c4_m_tvalid),
        .m_axis_tready   (c4_m_tready),
        .join_count      (c4_join_count)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        aresetn  = 1'b0;
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset;
        a_tdata = 32'h0; b_tdata = 32'h0; m_tready = 1'b0;
        c4_a_tdata = 8'h0; c4_b_tdata = 8'h0;
        c4_a_tvalid = 1'b0; c4_b_tvalid = 1'b0; c4_m_tready = 1'b0;
        do_reset();
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 64'h0 || join_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h count=%0d, required 0/0/0", m_tvalid, m_tdata, join_count);
        end
        aresetn = 1'b0; a_tvalid = 1'b1; b_tvalid = 1'b1;
        #1;
        checks++;
        if (a_tready !== 1'b0 || b_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: a=%b b=%b, required 0/0", a_tready, b_tready);
        end
        tick();
        do_reset();
    endtask

    task automatic test_wait_pair;
        do_reset();
        m_tready = 1'b1;
        a_tvalid = 1'b1; a_tdata = 32'h3F80_0000;
        b_tvalid = 1'b0; b_tdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (a_tready !== 1'b0 || b_tready !== 1'b0) begin
                errors++;
                $display("FAIL wait_tready cyc%0d: a=%b b=%b, required 0/0", i, a_tready, b_tready);
            end
            tick();
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL wait_mvalid cyc%0d: got %b, required 0", i, m_tvalid);
            end
        end
        b_tvalid = 1'b1; b_tdata = 32'h4000_0000;
        tick();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'h4000_0000_3F80_0000 || join_count !== 16'd1) begin
            errors++;
            $display("FAIL wait_join: valid=%b data=%h count=%0d, required 1/400000003f800000/1", m_tvalid, m_tdata, join_count);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL wait_drain: valid=%b, required 0", m_tvalid);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_tvalid = 1'b1; a_tdata = 32'(i);
            b_tvalid = 1'b1; b_tdata = 32'h100 + 32'(i);
            tick();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== {32'h100 + 32'(i), 32'(i)} || join_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL b2b beat%0d: valid=%b data=%h count=%0d, required 1/%h/%0d",
                         i, m_tvalid, m_tdata, join_count, {32'h100 + 32'(i), 32'(i)}, i + 1);
            end
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || join_count !== 16'd8) begin
            errors++;
            $display("FAIL b2b_end: valid=%b count=%0d, required 0/8", m_tvalid, join_count);
        end
    endtask

    task automatic test_backpressure;
        int p;
        int q;
        p = 0;
        q = 0;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_tvalid = 1'b1; a_tdata = 32'(p);
            b_tvalid = 1'b1; b_tdata = 32'h100 + 32'(p);
            #1;
            if (a_tready === 1'b1) p++;
            tick();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 64'h0000_0100_0000_0000) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h, required 1/0000010000000000", i, m_tvalid, m_tdata);
            end
        end
        checks++;
        if (p != STALL_ACCEPT || join_count !== 16'(STALL_ACCEPT)) begin
            errors++;
            $display("FAIL bp_accepted: pairs=%0d count=%0d, required %0d", p, join_count, STALL_ACCEPT);
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_tvalid === 1'b1) begin
                checks++;
                if (m_tdata !== {32'h100 + 32'(q), 32'(q)}) begin
                    errors++;
                    $display("FAIL bp_release beat%0d: got %h, required %h", q, m_tdata, {32'h100 + 32'(q), 32'(q)});
                end
                q++;
            end
            tick();
        end
        checks++;
        if (q != STALL_ACCEPT) begin
            errors++;
            $display("FAIL bp_release_count: got %0d, required %0d", q, STALL_ACCEPT);
        end
    endtask

    task automatic test_random;
        logic [63:0] exp_q[$];
        logic [63:0] exp_v;
        logic [63:0] prev_data;
        logic        prev_stall;
        logic [31:0] seq;
        int          fires;
        int          outs;
        seq = 32'h0; fires = 0; outs = 0; prev_stall = 1'b0; prev_data = 64'h0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            a_tvalid = 1'($urandom_range(0, 1));
            b_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            a_tdata  = a_tvalid ? seq : $urandom;
            b_tdata  = b_tvalid ? (seq ^ 32'hA5A5_0000) : $urandom;
            #2;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) begin
                checks++;
                errors++;
                $display("FAIL rnd_hold cyc%0d: valid=%b data=%h, required 1/%h", c, m_tvalid, m_tdata, prev_data);
            end
            if (a_tready !== b_tready || (a_tready === 1'b1 && !(a_tvalid && b_tvalid))) begin
                checks++;
                errors++;
                $display("FAIL rnd_tready cyc%0d: a=%b b=%b av=%b bv=%b", c, a_tready, b_tready, a_tvalid, b_tvalid);
            end
            if (a_tready === 1'b1) begin
                exp_q.push_back({b_tdata, a_tdata});
                seq = seq + 32'd1;
                fires++;
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                outs++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra cyc%0d: got %h, required no beat", c, m_tdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (m_tdata !== exp_v) begin
                        errors++;
                        $display("FAIL rnd_data cyc%0d: got %h, required %h", c, m_tdata, exp_v);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            tick();
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m_tvalid === 1'b1) begin
                checks++;
                outs++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                if (m_tdata !== exp_v) begin
                    errors++;
                    $display("FAIL rnd_drain: got %h, required %h", m_tdata, exp_v);
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || outs != fires || join_count !== 16'(fires)) begin
            errors++;
            $display("FAIL rnd_totals: left=%0d outs=%0d fires=%0d count=%0d", exp_q.size(), outs, fires, join_count);
        end
    endtask

    task automatic test_cnt_wrap;
        int f;
        f = 0;
        do_reset();
        c4_m_tready = 1'b1;
        c4_a_tvalid = 1'b1; c4_b_tvalid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            c4_a_tdata = 8'(i); c4_b_tdata = 8'(i + 1);
            #1;
            if (c4_a_tready === 1'b1) f++;
            tick();
            if (i == 15) begin
                checks++;
                if (c4_join_count !== 4'd0) begin
                    errors++;
                    $display("FAIL cnt4_wrap16: got %0d, required 0", c4_join_count);
                end
            end
        end
        c4_a_tvalid = 1'b0; c4_b_tvalid = 1'b0;
        tick();
        checks++;
        if (f != 17 || c4_join_count !== 4'd1) begin
            errors++;
            $display("FAIL cnt4_17: fires=%0d count=%0d, required 17/1", f, c4_join_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        m_tready = 1'b0;
        a_tvalid = 1'b1; a_tdata = 32'h1111_1111;
        b_tvalid = 1'b1; b_tdata = 32'h2222_2222;
        tick();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        checks++;
        if (m_tvalid !== 1'b0 || join_count !== 16'd0 || m_tdata !== 64'h0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b count=%0d data=%h, required 0/0/0", m_tvalid, join_count, m_tdata);
        end
        m_tready = 1'b1;
        tick();
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: valid=%b data=%h, required no beat", m_tvalid, m_tdata);
        end
        a_tvalid = 1'b1; a_tdata = 32'h3333_3333;
        b_tvalid = 1'b1; b_tdata = 32'h4444_4444;
        tick();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'h4444_4444_3333_3333 || join_count !== 16'd1) begin
            errors++;
            $display("FAIL midreset_new: valid=%b data=%h count=%0d, required 1/4444444433333333/1", m_tvalid, m_tdata, join_count);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: valid=%b data=%h, required 0", m_tvalid, m_tdata);
        end
    endtask

    initial begin
        test_reset();
        test_wait_pair();
        test_back_to_back();
        test_backpressure();
        test_cnt_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
